// File: rtl/ram_arbiter_pkg.sv
// Shared types and defaults for the two-requester RAM arbiter.
package ram_arbiter_pkg;

  localparam int unsigned DEFAULT_WIDTH_DATA    = 8;
  localparam int unsigned DEFAULT_WIDTH_ADDRESS = 20;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  // 0 = fetch unit, 1 = execution unit
  typedef logic req_id_t;

  function automatic logic [1:0] id_onehot(input req_id_t id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester, RAM and status signals of the arbiter, bundled as one interface.
interface ram_arbiter_if
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH_DATA    = DEFAULT_WIDTH_DATA,
  parameter int unsigned WIDTH_ADDRESS = DEFAULT_WIDTH_ADDRESS
);

  logic [1:0]                    req_valid;
  logic [1:0]                    req_write;
  logic [1:0]                    req_lock;
  logic [1:0][WIDTH_ADDRESS-1:0] req_address;
  logic [1:0][WIDTH_DATA-1:0]    req_wdata;
  logic [1:0]                    req_ack;
  logic [1:0]                    rsp_valid;
  logic [WIDTH_DATA-1:0]         rsp_data;

  logic                          ram_read_enable;
  logic                          ram_write_enable;
  logic [WIDTH_ADDRESS-1:0]      ram_read_address;
  logic [WIDTH_ADDRESS-1:0]      ram_write_address;
  logic [WIDTH_DATA-1:0]         ram_write_data;
  logic [WIDTH_DATA-1:0]         ram_read_data;

  logic                          busy;
  req_id_t                       grant_id;

  modport slave (
    input  req_valid, req_write, req_lock, req_address, req_wdata, ram_read_data,
    output req_ack, rsp_valid, rsp_data,
    output ram_read_enable, ram_write_enable, ram_read_address, ram_write_address,
    output ram_write_data, busy, grant_id
  );

  modport master (
    output req_valid, req_write, req_lock, req_address, req_wdata, ram_read_data,
    input  req_ack, rsp_valid, rsp_data,
    input  ram_read_enable, ram_write_enable, ram_read_address, ram_write_address,
    input  ram_write_data, busy, grant_id
  );

endinterface

// File: rtl/ram_arbiter_pick.sv
// Combinational 2-way picker: lock filtering followed by round-robin tie break.
module ram_arbiter_pick
  import ram_arbiter_pkg::*;
(
  input  logic [1:0] req_valid,
  input  logic       lock,
  input  req_id_t    last_grant,
  output logic       any,
  output req_id_t    winner
);

  logic [1:0] eligible;

  // The lock is only ever set on acceptance, so its owner is always the last winner.
  always_comb begin
    eligible = lock ? (req_valid & id_onehot(last_grant)) : req_valid;
    any      = |eligible;
    winner   = (eligible == 2'b11) ? ~last_grant : eligible[1];
  end

endmodule

// File: rtl/ram_arbiter.sv
// Non-pipelined RAM arbiter for fetch and execution units: one 3-cycle
// transaction at a time, round-robin with bus-lock support, registered outputs.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH_DATA    = DEFAULT_WIDTH_DATA,
  parameter int unsigned WIDTH_ADDRESS = DEFAULT_WIDTH_ADDRESS
)(
  input logic          clock,
  input logic          reset,
  ram_arbiter_if.slave bus
);

  state_t                   state;
  state_t                   state_next;
  logic                     pick_any;
  req_id_t                  pick_id;
  req_id_t                  last_grant;
  logic                     lock;
  logic                     lat_write;
  logic [WIDTH_ADDRESS-1:0] lat_address;
  logic [WIDTH_DATA-1:0]    lat_wdata;
  logic                     accept;
  logic [1:0]               ack_next;
  logic [1:0]               rsp_next;
  logic                     read_next;
  logic                     write_next;

  ram_arbiter_pick u_pick (
    .req_valid  (bus.req_valid),
    .lock       (lock),
    .last_grant (last_grant),
    .any        (pick_any),
    .winner     (pick_id)
  );

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    ack_next   = '0;
    rsp_next   = '0;
    read_next  = 1'b0;
    write_next = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_next = ACCESS;
          accept     = 1'b1;
          ack_next   = id_onehot(pick_id);
        end
      end
      ACCESS: begin
        state_next = RESP;
        read_next  = ~lat_write;
        write_next = lat_write;
      end
      RESP: begin
        state_next = IDLE;
        rsp_next   = id_onehot(bus.grant_id);
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Every output is a flop loaded from the decision taken in the previous state,
  // so strobes trail the state by one cycle and the RAM read data is sampled in RESP.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.req_ack           <= '0;
      bus.rsp_valid         <= '0;
      bus.rsp_data          <= '0;
      bus.ram_read_enable   <= 1'b0;
      bus.ram_write_enable  <= 1'b0;
      bus.ram_read_address  <= '0;
      bus.ram_write_address <= '0;
      bus.ram_write_data    <= '0;
      bus.busy              <= 1'b0;
      bus.grant_id          <= 1'b0;
      last_grant            <= 1'b1;
      lock                  <= 1'b0;
      lat_write             <= 1'b0;
      lat_address           <= '0;
      lat_wdata             <= '0;
    end else begin
      bus.req_ack          <= ack_next;
      bus.rsp_valid        <= rsp_next;
      bus.ram_read_enable  <= read_next;
      bus.ram_write_enable <= write_next;
      bus.busy             <= (state_next != IDLE);
      if (accept) begin
        bus.grant_id <= pick_id;
        last_grant   <= pick_id;
        lock         <= bus.req_lock[pick_id];
        lat_write    <= bus.req_write[pick_id];
        lat_address  <= bus.req_address[pick_id];
        lat_wdata    <= bus.req_wdata[pick_id];
      end
      if (read_next) bus.ram_read_address <= lat_address;
      if (write_next) begin
        bus.ram_write_address <= lat_address;
        bus.ram_write_data    <= lat_wdata;
      end
      if (state == RESP && !lat_write) bus.rsp_data <= bus.ram_read_data;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed vector table, hand-written corner sequences
// and a randomized phase checked against a transaction-level reference model.
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  localparam int unsigned WD = 8;
  localparam int unsigned WA = 20;

  logic clock;
  logic reset;

  ram_arbiter_if #(.WIDTH_DATA(WD), .WIDTH_ADDRESS(WA)) bus ();

  ram_arbiter #(.WIDTH_DATA(WD), .WIDTH_ADDRESS(WA)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM model: read data presented while the read strobe is high, writes on the edge.
  logic [7:0] mem [256];

  function automatic logic [7:0] init_val(input int unsigned a);
    return (a == 1) ? 8'h5A : 8'(a ^ 32'h3C);
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else if (bus.ram_write_enable) begin
      mem[bus.ram_write_address[7:0]] <= bus.ram_write_data;
    end
  end

  assign bus.ram_read_data = bus.ram_read_enable ? mem[bus.ram_read_address[7:0]] : 8'hEE;

  logic [63:0] all_out;
  assign all_out = {bus.req_ack, bus.rsp_valid, bus.rsp_data, bus.ram_read_enable,
                    bus.ram_write_enable, bus.ram_read_address, bus.ram_write_address,
                    bus.ram_write_data, bus.busy, bus.grant_id};

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [1:0]  valid;
    logic [1:0]  write;
    logic [1:0]  lock;
    logic [19:0] a0;
    logic [19:0] a1;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic [1:0]  ack;
    logic [7:0]  rsp;
  } vec_t;

  function automatic vec_t mkv(input logic [1:0] valid, input logic [1:0] write,
                               input logic [1:0] lock, input logic [19:0] a0,
                               input logic [19:0] a1, input logic [7:0] d0,
                               input logic [7:0] d1, input logic [1:0] ack,
                               input logic [7:0] rsp);
    vec_t v;
    v.valid = valid; v.write = write; v.lock = lock;
    v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
    v.ack = ack; v.rsp = rsp;
    return v;
  endfunction

  // Applies one vector from an idle cycle (called right after a falling edge).
  task automatic run_vec(input vec_t v);
    int          w;
    logic [19:0] a;
    logic [7:0]  d;
    bus.req_valid      = v.valid;
    bus.req_write      = v.write;
    bus.req_lock       = v.lock;
    bus.req_address[0] = v.a0;
    bus.req_address[1] = v.a1;
    bus.req_wdata[0]   = v.d0;
    bus.req_wdata[1]   = v.d1;
    if (v.ack == 2'b00) begin
      repeat (4) begin
        @(negedge clock);
        check("blocked_ack", 64'(bus.req_ack), 64'(2'b00));
        check("blocked_busy", 64'(bus.busy), 64'(1'b0));
      end
      bus.req_valid = '0;
      return;
    end
    w = v.ack[1] ? 1 : 0;
    a = (w == 1) ? v.a1 : v.a0;
    d = (w == 1) ? v.d1 : v.d0;
    @(negedge clock);
    check("ack", 64'(bus.req_ack), 64'(v.ack));
    check("grant_id", 64'(bus.grant_id), 64'(w));
    check("busy_access", 64'(bus.busy), 64'(1'b1));
    bus.req_valid[w]   = 1'b0;
    bus.req_address[w] = ~a;
    bus.req_wdata[w]   = ~d;
    bus.req_write[w]   = ~v.write[w];
    @(negedge clock);
    check("strobes", 64'({bus.ram_read_enable, bus.ram_write_enable}),
          64'({~v.write[w], v.write[w]}));
    check("ack_gone", 64'(bus.req_ack), 64'(2'b00));
    if (v.write[w]) begin
      check("wr_addr", 64'(bus.ram_write_address), 64'(a));
      check("wr_data", 64'(bus.ram_write_data), 64'(d));
    end else begin
      check("rd_addr", 64'(bus.ram_read_address), 64'(a));
    end
    @(negedge clock);
    check("rsp_valid", 64'(bus.rsp_valid), 64'(v.ack));
    check("rsp_data", 64'(bus.rsp_data), 64'(v.rsp));
    check("busy_done", 64'(bus.busy), 64'(1'b0));
    check("strobes_off", 64'({bus.ram_read_enable, bus.ram_write_enable}), 64'(2'b00));
    bus.req_valid = '0;
  endtask

  // Reference model state for the randomized phase.
  logic [1:0]  pv, pw, pl;
  logic [19:0] pa [2];
  logic [7:0]  pd [2];
  logic        m_last, m_owner, m_lock;
  logic [7:0]  m_rsp;
  logic [7:0]  ref_mem [256];

  task automatic gen_reqs();
    for (int r = 0; r < 2; r++) begin
      if (!pv[r] && $urandom_range(0, 1) == 1) begin
        pv[r] = 1'b1;
        pw[r] = 1'($urandom_range(0, 1));
        pl[r] = ($urandom_range(0, 3) == 0);
        pa[r] = {12'($urandom), 8'($urandom_range(0, 31))};
        pd[r] = 8'($urandom);
      end
    end
    bus.req_valid      = pv;
    bus.req_write      = pw;
    bus.req_lock       = pl;
    bus.req_address[0] = pa[0];
    bus.req_address[1] = pa[1];
    bus.req_wdata[0]   = pd[0];
    bus.req_wdata[1]   = pd[1];
  endtask

  // Who should be served next: only the lock owner while locked, else the
  // sole requester, else the one not served last. -1 means nobody.
  function automatic int exp_winner();
    logic ok0, ok1;
    ok0 = pv[0] && (!m_lock || m_owner == 1'b0);
    ok1 = pv[1] && (!m_lock || m_owner == 1'b1);
    if (ok0 && ok1) return (m_last == 1'b1) ? 0 : 1;
    if (ok0) return 0;
    if (ok1) return 1;
    return -1;
  endfunction

  vec_t tbl [15];

  initial begin
    int exp_id;
    tbl[0]  = mkv(2'b01, 2'b00, 2'b00, 20'h00001, 20'h0,     8'h0, 8'h0,  2'b01, 8'h5A);
    tbl[1]  = mkv(2'b10, 2'b10, 2'b00, 20'h0,     20'h00010, 8'h0, 8'h10, 2'b10, 8'h5A);
    tbl[2]  = mkv(2'b01, 2'b00, 2'b00, 20'h00010, 20'h0,     8'h0, 8'h0,  2'b01, 8'h10);
    tbl[3]  = mkv(2'b11, 2'b00, 2'b00, 20'h00002, 20'h00003, 8'h0, 8'h0,  2'b10, 8'h3F);
    tbl[4]  = mkv(2'b11, 2'b00, 2'b00, 20'hFFFFF, 20'h00004, 8'h0, 8'h0,  2'b01, 8'hC3);
    tbl[5]  = mkv(2'b01, 2'b00, 2'b00, 20'h00006, 20'h0,     8'h0, 8'h0,  2'b01, 8'h3A);
    tbl[6]  = mkv(2'b10, 2'b00, 2'b10, 20'h0,     20'h00007, 8'h0, 8'h0,  2'b10, 8'h3B);
    tbl[7]  = mkv(2'b11, 2'b00, 2'b10, 20'h00008, 20'h00009, 8'h0, 8'h0,  2'b10, 8'h35);
    tbl[8]  = mkv(2'b11, 2'b00, 2'b10, 20'h00008, 20'h0000A, 8'h0, 8'h0,  2'b10, 8'h36);
    tbl[9]  = mkv(2'b11, 2'b00, 2'b00, 20'h00008, 20'h0000B, 8'h0, 8'h0,  2'b10, 8'h37);
    tbl[10] = mkv(2'b11, 2'b00, 2'b00, 20'h0000C, 20'h0000D, 8'h0, 8'h0,  2'b01, 8'h30);
    tbl[11] = mkv(2'b10, 2'b10, 2'b10, 20'h0,     20'h00020, 8'h0, 8'h77, 2'b10, 8'h30);
    tbl[12] = mkv(2'b01, 2'b00, 2'b00, 20'h00020, 20'h0,     8'h0, 8'h0,  2'b00, 8'h30);
    tbl[13] = mkv(2'b11, 2'b00, 2'b00, 20'h00020, 20'h00021, 8'h0, 8'h0,  2'b10, 8'h1D);
    tbl[14] = mkv(2'b01, 2'b00, 2'b00, 20'h00020, 20'h0,     8'h0, 8'h0,  2'b01, 8'h77);

    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_lock  = '0;
    bus.req_address = '0;
    bus.req_wdata   = '0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_outputs", all_out, 64'h0);
    reset = 1'b0;

    for (int i = 0; i < 15; i++) run_vec(tbl[i]);

    // Both requesters held continuously: alternating grants, one every 3 cycles.
    bus.req_valid      = 2'b11;
    bus.req_write      = 2'b00;
    bus.req_lock       = 2'b00;
    bus.req_address[0] = 20'h00001;
    bus.req_address[1] = 20'h00002;
    exp_id = 1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      if (k % 3 == 1) begin
        check("rr_ack", 64'(bus.req_ack), (exp_id == 1) ? 64'h2 : 64'h1);
        exp_id = 1 - exp_id;
      end else begin
        check("rr_gap", 64'(bus.req_ack), 64'h0);
      end
    end
    bus.req_valid = '0;

    // Reset while the read strobe is out: abort without a response.
    bus.req_valid      = 2'b01;
    bus.req_write      = 2'b00;
    bus.req_address[0] = 20'h00001;
    @(negedge clock);
    check("abort_ack", 64'(bus.req_ack), 64'h1);
    bus.req_valid = '0;
    @(negedge clock);
    check("abort_strobe", 64'(bus.ram_read_enable), 64'h1);
    #1 reset = 1'b1;
    #1 check("async_reset", all_out, 64'h0);
    @(negedge clock);
    check("abort_no_rsp", 64'(bus.rsp_valid), 64'h0);
    @(negedge clock);
    reset = 1'b0;
    run_vec(mkv(2'b11, 2'b00, 2'b00, 20'h00001, 20'h00002, 8'h0, 8'h0, 2'b01, 8'h5A));

    // Randomized phase from a fresh reset.
    reset = 1'b1;
    pv = '0; pw = '0; pl = '0;
    pa[0] = '0; pa[1] = '0; pd[0] = '0; pd[1] = '0;
    bus.req_valid = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    m_last = 1'b1; m_owner = 1'b1; m_lock = 1'b0; m_rsp = 8'h00;
    for (int unsigned i = 0; i < 256; i++) ref_mem[i] = init_val(i);

    for (int it = 0; it < 200; it++) begin
      int          w;
      logic        wr;
      logic [19:0] a;
      logic [7:0]  d;
      gen_reqs();
      w = exp_winner();
      @(negedge clock);
      check("rand_ack", 64'(bus.req_ack), (w < 0) ? 64'h0 : ((w == 1) ? 64'h2 : 64'h1));
      if (w < 0) continue;
      wr = pw[w]; a = pa[w]; d = pd[w];
      m_last  = (w == 1);
      m_owner = (w == 1);
      m_lock  = pl[w];
      pv[w] = 1'b0; pa[w] = ~pa[w]; pd[w] = ~pd[w];
      gen_reqs();
      @(negedge clock);
      check("rand_strobes", 64'({bus.ram_read_enable, bus.ram_write_enable}), 64'({~wr, wr}));
      if (wr) begin
        check("rand_wr_addr", 64'(bus.ram_write_address), 64'(a));
        check("rand_wr_data", 64'(bus.ram_write_data), 64'(d));
        ref_mem[a[7:0]] = d;
      end else begin
        check("rand_rd_addr", 64'(bus.ram_read_address), 64'(a));
        m_rsp = ref_mem[a[7:0]];
      end
      @(negedge clock);
      check("rand_rsp_valid", 64'(bus.rsp_valid), (w == 1) ? 64'h2 : 64'h1);
      check("rand_rsp_data", 64'(bus.rsp_data), 64'(m_rsp));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before the bench completed");
    $fatal(1);
  end

endmodule
